sipo_deframer: RTL

//   Serial-in/parallel-out receive stage; sits directly downstream of the 4-bit PISO shifter.

---
 rtl/sipo_deframer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sipo_deframer.sv
// Serial-in/parallel-out deframer: rebuilds WIDTH-bit words aligned to frame_start and
// hands them out through a one-entry valid/ready register. Optional macro SIPO_OVERRUN_CNT_EN adds overrun_cnt.
module sipo_deframer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  input  logic             bit_en,
  input  logic             frame_start,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
`ifdef SIPO_OVERRUN_CNT_EN
  ,
  output logic [7:0]       overrun_cnt
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] sr_shift_s;
  logic             complete_s;
`ifdef SIPO_OVERRUN_CNT_EN
  logic [7:0]       ovr_cnt_q, ovr_cnt_d;
`endif

  // Shift register with the current bit included, in the configured direction
  always_comb begin
    sr_shift_s = sr_q;
    if (MSB_FIRST) begin
      sr_shift_s = {sr_q[WIDTH-2:0], serial_in};
    end else begin
      sr_shift_s = {serial_in, sr_q[WIDTH-1:1]};
    end
  end

  // Framing FSM and holding-register handshake next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    hold_d     = hold_q;
    valid_d    = valid_q;
    ferr_d     = 1'b0;
    ovr_d      = ovr_q;
    complete_s = 1'b0;
`ifdef SIPO_OVERRUN_CNT_EN
    ovr_cnt_d  = ovr_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bit_en && frame_start) begin
          sr_d    = sr_shift_s;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (bit_en && frame_start) begin
          // A new frame restarts assembly; the partial word is abandoned
          ferr_d = 1'b1;
          sr_d   = sr_shift_s;
          cnt_d  = CW'(1);
        end else if (bit_en) begin
          sr_d = sr_shift_s;
          if (cnt_q == CNT_LAST) begin
            complete_s = 1'b1;
            cnt_d      = '0;
            state_d    = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (complete_s) begin
      if (!valid_q || out_ready) begin
        hold_d  = sr_shift_s;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
`ifdef SIPO_OVERRUN_CNT_EN
        if (ovr_cnt_q != 8'hFF) begin
          ovr_cnt_d = ovr_cnt_q + 8'd1;
        end else begin
          ovr_cnt_d = ovr_cnt_q;
        end
`endif
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      hold_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef SIPO_OVERRUN_CNT_EN
      ovr_cnt_q <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
`ifdef SIPO_OVERRUN_CNT_EN
      ovr_cnt_q <= ovr_cnt_d;
`endif
    end
  end

  assign parallel_out = hold_q;
  assign out_valid    = valid_q;
  assign busy         = (state_q == SHIFT);
  assign frame_err    = ferr_q;
  assign overrun      = ovr_q;
`ifdef SIPO_OVERRUN_CNT_EN
  assign overrun_cnt  = ovr_cnt_q;
`endif

endmodule
